divide_seq: RTL and testbench

Sequential restoring divider that inverts multiply_for: takes a 16-bit dividend and an 8-bit divisor and returns a 16-bit quotient and an 8-bit remainder.
Computes one quotient bit per clock under a start/done handshake.
Sits beside the multiplier in the arithmetic datapath, so that a multiply followed by a divide round-trips operands.

---
 rtl/divide_seq.sv | 160 ++++++++++++++++
 tb/tb_divide_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/divide_seq.sv
// Sequential restoring divider: WIDTH_N-bit dividend / WIDTH_D-bit divisor, one quotient bit per clock.
// Optional two's-complement operation is enabled by defining DIVIDE_SIGNED_EN.
module divide_seq #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_by_zero
);

    localparam int CNT_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH_N-1:0] dvd_q;       // dividend shifts out MSB-first, quotient shifts in at LSB
    logic [WIDTH_D-1:0] dvs_q;
    logic [WIDTH_D-1:0] p_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH_N-1:0] quotient_q;
    logic [WIDTH_D-1:0] remainder_q;
    logic               dbz_q;

    logic               accept;
    logic               finish;
    logic [WIDTH_D:0]   p_shift;
    logic [WIDTH_D+1:0] t_ext;
    logic               qbit;
    logic [WIDTH_D-1:0] p_d;
    logic [WIDTH_N-1:0] dvd_d;
    logic [WIDTH_N-1:0] dvd_load;
    logic [WIDTH_D-1:0] dvs_load;

`ifdef DIVIDE_SIGNED_EN
    logic neg_q_q;
    logic neg_r_q;

    function automatic logic [WIDTH_N-1:0] abs_n(input logic [WIDTH_N-1:0] v);
        return v[WIDTH_N-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH_D-1:0] abs_d(input logic [WIDTH_D-1:0] v);
        return v[WIDTH_D-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH_N-1:0] fix_q(input logic [WIDTH_N-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH_D-1:0] fix_r(input logic [WIDTH_D-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign dvd_load = abs_n(dividend);
    assign dvs_load = abs_d(divisor);
`else
    assign dvd_load = dividend;
    assign dvs_load = divisor;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    finish  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Restoring step; the extra top bit of t_ext is the sign of P - divisor.
    always_comb begin
        p_shift = {p_q, dvd_q[WIDTH_N-1]};
        t_ext   = {1'b0, p_shift} - {2'b00, dvs_q};
        qbit    = ~t_ext[WIDTH_D+1];
        p_d     = qbit ? t_ext[WIDTH_D-1:0] : p_shift[WIDTH_D-1:0];
        dvd_d   = {dvd_q[WIDTH_N-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (divisor == '0) begin
                    quotient_q  <= '1;
                    remainder_q <= dividend[WIDTH_D-1:0];
                    dbz_q       <= 1'b1;
                end else begin
                    dbz_q <= 1'b0;
                end
            end
            if (finish) begin
`ifdef DIVIDE_SIGNED_EN
                quotient_q  <= fix_q(dvd_d, neg_q_q);
                remainder_q <= fix_r(p_d, neg_r_q);
`else
                quotient_q  <= dvd_d;
                remainder_q <= p_d;
`endif
            end
        end
    end

    // Working registers need no reset: every accepted start reloads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_q <= dvd_load;
            dvs_q <= dvs_load;
            p_q   <= '0;
            cnt_q <= '0;
`ifdef DIVIDE_SIGNED_EN
            neg_q_q <= dividend[WIDTH_N-1] ^ divisor[WIDTH_D-1];
            neg_r_q <= dividend[WIDTH_N-1];
`endif
        end else if (state_q == S_RUN) begin
            dvd_q <= dvd_d;
            p_q   <= p_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divide_seq.sv
// Self-checking bench for divide_seq: directed cases plus a random sweep against an arithmetic reference.
module tb_divide_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int fails  = 0;

    divide_seq #(.WIDTH_N(16), .WIDTH_D(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division from the operand rules.
    task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                           output logic [15:0] q, output logic [7:0] r,
                           output logic z, output int lat);
        int sa, sb, sq, sr;
        if (b == 8'd0) begin
            q = 16'hFFFF; r = a[7:0]; z = 1'b1; lat = 1;
        end else begin
`ifdef DIVIDE_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            sq = sa / sb;
            sr = sa % sb;
            q = sq[15:0]; r = sr[7:0]; z = 1'b0; lat = 17;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one start and waits (bounded) for done; lat counts edges from the accepting edge.
    task automatic do_div(input logic [15:0] a, input logic [7:0] b, output int lat);
        dividend = a; divisor = b; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Runs one division and checks latency, results, single-cycle done and held outputs.
    task automatic run_and_check(input string tag, input logic [15:0] a, input logic [7:0] b);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        int          elat, lat;
        ref_div(a, b, eq, er, ez, elat);
        do_div(a, b, lat);
        check({tag, " latency"}, lat, elat);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " dbz"}, div_by_zero, ez);
        tick();
        check({tag, " done pulse"}, done, 1'b0);
        check({tag, " held q"}, quotient, eq);
    endtask

    initial begin
        int lat, n_done;
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        int          elat;

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quotient", quotient, 16'd0);
        check("reset remainder", remainder, 8'd0);
        check("reset dbz", div_by_zero, 1'b0);

`ifndef DIVIDE_SIGNED_EN
        do_div(16'd1000, 8'd7, lat);
        check("1000/7 latency", lat, 17);
        check("1000/7 q", quotient, 16'd142);
        check("1000/7 r", remainder, 8'd6);
        check("1000/7 dbz", div_by_zero, 1'b0);
        tick();

        do_div(16'd65535, 8'd255, lat);
        check("65535/255 q", quotient, 16'd257);
        check("65535/255 r", remainder, 8'd0);
        tick();

        do_div(16'd255, 8'd0, lat);
        check("255/0 latency", lat, 1);
        check("255/0 q", quotient, 16'hFFFF);
        check("255/0 r", remainder, 8'hFF);
        check("255/0 dbz", div_by_zero, 1'b1);
        tick();
        check("255/0 done pulse", done, 1'b0);
        check("255/0 dbz held", div_by_zero, 1'b1);

        // Extra starts during RUN must be ignored, not queued.
        dividend = 16'd500; divisor = 8'd3; start = 1'b1;
        tick();
        check("500/3 dbz cleared", div_by_zero, 1'b0);
        check("500/3 busy", busy, 1'b1);
        dividend = 16'd9; divisor = 8'd9;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            start = lat[0];
            tick();
            lat++;
        end
        start = 1'b0;
        check("500/3 latency", lat, 17);
        check("500/3 q", quotient, 16'd166);
        check("500/3 r", remainder, 8'd2);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("500/3 no queued start", n_done, 0);
        check("500/3 held r", remainder, 8'd2);
        run_and_check("100/10 after ignore", 16'd100, 8'd10);

        // Reset in the middle of RUN aborts without done.
        dividend = 16'd1234; divisor = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("abort busy before reset", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort q", quotient, 16'd0);
        check("abort r", remainder, 8'd0);
        check("abort busy", busy, 1'b0);
        check("abort dbz", div_by_zero, 1'b0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) n_done++;
            tick();
        end
        check("abort no done", n_done, 0);
        do_div(16'd1234, 8'd5, lat);
        check("1234/5 q", quotient, 16'd246);
        check("1234/5 r", remainder, 8'd4);
        tick();
        run_and_check("0/9", 16'd0, 8'd9);
`else
        do_div(16'hFFF9, 8'd2, lat);
        check("-7/2 latency", lat, 17);
        check("-7/2 q", quotient, 16'hFFFD);
        check("-7/2 r", remainder, 8'hFF);
        tick();
        do_div(16'd7, 8'hFE, lat);
        check("7/-2 q", quotient, 16'hFFFD);
        check("7/-2 r", remainder, 8'h01);
        tick();
        do_div(16'h8000, 8'hFF, lat);
        check("-32768/-1 q", quotient, 16'h8000);
        check("-32768/-1 r", remainder, 8'h00);
        tick();
        run_and_check("-5/0", 16'hFFFB, 8'd0);
        run_and_check("-100/-7", 16'hFF9C, 8'hF9);
`endif

        for (int i = 0; i < 3000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 8'd0;
                1:       b = 8'($urandom_range(1, 4));
                default: b = 8'($urandom);
            endcase
            run_and_check("random", a, b);
`ifndef DIVIDE_SIGNED_EN
            if (b != 8'd0) begin
                check("random invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                check("random rem<div", remainder < b, 1'b1);
            end
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
